// File: rtl/bram_port_arbiter.sv
// Two-requester arbiter for a single BRAM port: same-cycle round-robin grant,
// optional burst lock, and routing of returning read data to the issuing requester.
module bram_port_arbiter #(
   parameter int DW         = 32,
   parameter int AW         = 32,
   parameter int RD_LATENCY = 1
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              req0,
   input  logic              req1,
   input  logic              lock0,
   input  logic              lock1,
   input  logic [DW/8-1:0]   we0,
   input  logic [DW/8-1:0]   we1,
   input  logic [AW-1:0]     addr0,
   input  logic [AW-1:0]     addr1,
   input  logic [DW-1:0]     wdata0,
   input  logic [DW-1:0]     wdata1,
   output logic              gnt0,
   output logic              gnt1,
   output logic              rvalid0,
   output logic              rvalid1,
   output logic [DW-1:0]     rdata,
   output logic              mem_en,
   output logic [DW/8-1:0]   mem_we,
   output logic [AW-1:0]     mem_addr,
   output logic [DW-1:0]     mem_wdata,
   input  logic [DW-1:0]     mem_rdata,
   output logic [1:0]        owner
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      LOCK0 = 2'd1,
      LOCK1 = 2'd2
   } lock_state_t;

   lock_state_t lock_state_q, lock_state_d;
   logic        rr_last_q, rr_last_d;

   // A lock holder that drops its request releases the port in the same cycle,
   // so the other requester is arbitrated under the ordinary rules right away.
   always_comb begin
      gnt0         = 1'b0;
      gnt1         = 1'b0;
      lock_state_d = lock_state_q;
      rr_last_d    = rr_last_q;
      if (!reset) begin
         if (lock_state_q == LOCK0 && req0) begin
            gnt0 = 1'b1;
         end else if (lock_state_q == LOCK1 && req1) begin
            gnt1 = 1'b1;
         end else if (req0 && req1) begin
            gnt0 = rr_last_q;
            gnt1 = ~rr_last_q;
         end else begin
            gnt0 = req0;
            gnt1 = req1;
         end
      end
      if (gnt0) begin
         rr_last_d    = 1'b0;
         lock_state_d = lock0 ? LOCK0 : IDLE;
      end else if (gnt1) begin
         rr_last_d    = 1'b1;
         lock_state_d = lock1 ? LOCK1 : IDLE;
      end else begin
         lock_state_d = IDLE;
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         lock_state_q <= IDLE;
         rr_last_q    <= 1'b1;
      end else begin
         lock_state_q <= lock_state_d;
         rr_last_q    <= rr_last_d;
      end
   end

   assign owner  = lock_state_q;
   assign mem_en = gnt0 | gnt1;

   always_comb begin
      mem_we    = '0;
      mem_addr  = '0;
      mem_wdata = '0;
      if (gnt0) begin
         mem_we    = we0;
         mem_addr  = addr0;
         mem_wdata = wdata0;
      end else if (gnt1) begin
         mem_we    = we1;
         mem_addr  = addr1;
         mem_wdata = wdata1;
      end
   end

   // Read tag pipeline: one {valid, id} per cycle of BRAM latency.
   logic [RD_LATENCY-1:0] rd_valid_q, rd_valid_d;
   logic [RD_LATENCY-1:0] rd_id_q, rd_id_d;

   assign rd_valid_d[0] = mem_en & (mem_we == '0);
   assign rd_id_d[0]    = gnt1;

   for (genvar gi = 1; gi < RD_LATENCY; gi++) begin : g_rd_shift
      assign rd_valid_d[gi] = rd_valid_q[gi-1];
      assign rd_id_d[gi]    = rd_id_q[gi-1];
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         rd_valid_q <= '0;
         rd_id_q    <= '0;
      end else begin
         rd_valid_q <= rd_valid_d;
         rd_id_q    <= rd_id_d;
      end
   end

   assign rvalid0 = rd_valid_q[RD_LATENCY-1] & ~rd_id_q[RD_LATENCY-1];
   assign rvalid1 = rd_valid_q[RD_LATENCY-1] &  rd_id_q[RD_LATENCY-1];
   assign rdata   = mem_rdata;

endmodule

// File: tb/tb_bram_port_arbiter.sv
// Bench for bram_port_arbiter: three instances (read latency 1, 2, 3) share one
// stimulus stream and are compared each cycle against a behavioural model.
module tb_bram_port_arbiter;
   localparam int DW = 32;
   localparam int AW = 32;
   localparam int BW = DW/8;
   localparam int NI = 3;
   localparam int HN = 8192;

   logic clock = 1'b0;
   logic reset;
   logic req0, req1, lock0, lock1;
   logic [BW-1:0] we0, we1;
   logic [AW-1:0] addr0, addr1;
   logic [DW-1:0] wdata0, wdata1;

   logic [NI-1:0]          gnt0_v, gnt1_v, rvalid0_v, rvalid1_v, mem_en_v;
   logic [NI-1:0][BW-1:0]  mem_we_v;
   logic [NI-1:0][AW-1:0]  mem_addr_v;
   logic [NI-1:0][DW-1:0]  mem_wdata_v, rdata_v, mem_rdata_v;
   logic [NI-1:0][1:0]     owner_v;

   logic [DW-1:0] bram [64] = '{default: '0};
   logic [DW-1:0] bpipe [NI][4];

   always #5 clock = ~clock;

   for (genvar gi = 0; gi < NI; gi++) begin : g_dut
      bram_port_arbiter #(.DW(DW), .AW(AW), .RD_LATENCY(gi+1)) u_dut (
         .clock     (clock),
         .reset     (reset),
         .req0      (req0),
         .req1      (req1),
         .lock0     (lock0),
         .lock1     (lock1),
         .we0       (we0),
         .we1       (we1),
         .addr0     (addr0),
         .addr1     (addr1),
         .wdata0    (wdata0),
         .wdata1    (wdata1),
         .gnt0      (gnt0_v[gi]),
         .gnt1      (gnt1_v[gi]),
         .rvalid0   (rvalid0_v[gi]),
         .rvalid1   (rvalid1_v[gi]),
         .rdata     (rdata_v[gi]),
         .mem_en    (mem_en_v[gi]),
         .mem_we    (mem_we_v[gi]),
         .mem_addr  (mem_addr_v[gi]),
         .mem_wdata (mem_wdata_v[gi]),
         .mem_rdata (mem_rdata_v[gi]),
         .owner     (owner_v[gi])
      );
      assign mem_rdata_v[gi] = bpipe[gi][gi];
   end

   // BRAM stand-in: byte-writable words, read data delayed by each instance's latency.
   always @(posedge clock) begin
      if (mem_en_v[0]) begin
         for (int b = 0; b < BW; b++)
            if (mem_we_v[0][b]) bram[mem_addr_v[0][7:2]][8*b +: 8] <= mem_wdata_v[0][8*b +: 8];
      end
      for (int k = 0; k < NI; k++) begin
         bpipe[k][0] <= bram[mem_addr_v[k][7:2]];
         for (int j = 1; j < 4; j++) bpipe[k][j] <= bpipe[k][j-1];
      end
   end

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int win = -1;
   int m_owner = 0;
   int m_last = 1;
   logic hv [HN];
   logic hid [HN];
   logic [DW-1:0] hd [HN];
   logic [DW-1:0] model_mem [64];

   task automatic chkw(string tag, int k, logic [DW-1:0] obs, logic [DW-1:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s[L=%0d]: observed %h expected %h", tag, k+1, obs, exp);
      end
   endtask

   task automatic chkb(string tag, int k, logic obs, logic exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s[L=%0d]: observed %b expected %b", tag, k+1, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_owner = 0;
      m_last  = 1;
      for (int i = 0; i < HN; i++) hv[i] = 1'b0;
   endtask

   // Lock holder wins while it asks; otherwise any single asker wins, and on a
   // tie the requester not served most recently wins.
   task automatic model_pick();
      logic want [2];
      want[0] = req0;
      want[1] = req1;
      win = -1;
      if (!reset) begin
         if (m_owner != 0 && want[m_owner-1]) win = m_owner - 1;
         else if (want[0] && want[1])         win = 1 - m_last;
         else if (want[0])                    win = 0;
         else if (want[1])                    win = 1;
      end
   endtask

   task automatic settle();
      int L;
      logic pv;
      logic pid;
      logic [BW-1:0] ewe;
      logic [AW-1:0] ead;
      logic [DW-1:0] ewd;
      #1;
      model_pick();
      ewe = '0; ead = '0; ewd = '0;
      if (win == 0) begin ewe = we0; ead = addr0; ewd = wdata0; end
      if (win == 1) begin ewe = we1; ead = addr1; ewd = wdata1; end
      for (int k = 0; k < NI; k++) begin
         L = k + 1;
         pv = 1'b0;
         pid = 1'b0;
         if (cyc >= L) begin pv = hv[cyc-L]; pid = hid[cyc-L]; end
         chkb("gnt0", k, gnt0_v[k], win == 0);
         chkb("gnt1", k, gnt1_v[k], win == 1);
         chkb("mem_en", k, mem_en_v[k], win >= 0);
         chkw("mem_we", k, DW'(mem_we_v[k]), DW'(ewe));
         chkw("mem_addr", k, mem_addr_v[k], ead);
         chkw("mem_wdata", k, mem_wdata_v[k], ewd);
         chkw("owner", k, DW'(owner_v[k]), DW'(m_owner));
         chkb("rvalid0", k, rvalid0_v[k], pv && !pid);
         chkb("rvalid1", k, rvalid1_v[k], pv && pid);
         chkw("rdata_pass", k, rdata_v[k], mem_rdata_v[k]);
         if (pv) chkw("rdata", k, rdata_v[k], hd[cyc-L]);
      end
   endtask

   task automatic clk();
      logic [BW-1:0] w;
      logic [AW-1:0] a;
      logic [DW-1:0] d;
      logic lk;
      @(posedge clock);
      hv[cyc] = 1'b0;
      if (win >= 0) begin
         w  = (win == 1) ? we1 : we0;
         a  = (win == 1) ? addr1 : addr0;
         d  = (win == 1) ? wdata1 : wdata0;
         lk = (win == 1) ? lock1 : lock0;
         hv[cyc]  = (w == '0);
         hid[cyc] = (win == 1);
         hd[cyc]  = model_mem[a[7:2]];
         for (int b = 0; b < BW; b++)
            if (w[b]) model_mem[a[7:2]][8*b +: 8] = d[8*b +: 8];
         m_last  = win;
         m_owner = lk ? win + 1 : 0;
      end else begin
         m_owner = 0;
      end
      cyc++;
      @(negedge clock);
   endtask

   task automatic set0(logic r, logic l, logic [BW-1:0] w, logic [AW-1:0] a, logic [DW-1:0] d);
      req0 = r; lock0 = l; we0 = w; addr0 = a; wdata0 = d;
   endtask

   task automatic set1(logic r, logic l, logic [BW-1:0] w, logic [AW-1:0] a, logic [DW-1:0] d);
      req1 = r; lock1 = l; we1 = w; addr1 = a; wdata1 = d;
   endtask

   task automatic do_reset();
      set0(1'b0, 1'b0, '0, '0, '0);
      set1(1'b0, 1'b0, '0, '0, '0);
      reset = 1'b1;
      model_reset();
      settle();
      clk();
      reset = 1'b0;
   endtask

   task automatic rand0();
      set0(($urandom % 3) != 0, ($urandom % 4) == 0, ($urandom % 2) ? '0 : BW'($urandom),
           AW'($urandom), DW'($urandom));
   endtask

   task automatic rand1();
      set1(($urandom % 3) != 0, ($urandom % 4) == 0, ($urandom % 2) ? '0 : BW'($urandom),
           AW'($urandom), DW'($urandom));
   endtask

   initial begin
      for (int i = 0; i < 64; i++) model_mem[i] = '0;
      set0(1'b0, 1'b0, '0, '0, '0);
      set1(1'b0, 1'b0, '0, '0, '0);
      reset = 1'b1;
      model_reset();
      @(negedge clock);
      do_reset();

      // single write from requester 0
      set0(1'b1, 1'b0, 4'h1, 32'h10, 32'h000000AB);
      settle();
      chkb("t1_gnt0", 0, gnt0_v[0], 1'b1);
      chkb("t1_gnt1", 0, gnt1_v[0], 1'b0);
      chkb("t1_en", 0, mem_en_v[0], 1'b1);
      chkw("t1_we", 0, DW'(mem_we_v[0]), 32'h1);
      chkw("t1_addr", 0, mem_addr_v[0], 32'h10);
      clk();
      set0(1'b0, 1'b0, '0, '0, '0);
      settle();
      chkb("t1_norv", 0, rvalid0_v[0], 1'b0);
      clk();

      // contending reads alternate
      do_reset();
      set0(1'b1, 1'b0, '0, 32'h10, '0);
      set1(1'b1, 1'b0, '0, 32'h44, '0);
      for (int i = 0; i < 4; i++) begin
         settle();
         chkb("t2_gnt0", 0, gnt0_v[0], (i % 2) == 0);
         chkb("t2_gnt1", 0, gnt1_v[0], (i % 2) == 1);
         if (i > 0) chkb("t2_rv0", 0, rvalid0_v[0], (i % 2) == 1);
         clk();
      end
      set0(1'b0, 1'b0, '0, '0, '0);
      set1(1'b0, 1'b0, '0, '0, '0);
      settle();
      chkb("t2_rv1_last", 0, rvalid1_v[0], 1'b1);
      clk();

      // locked burst from requester 0 against a waiting requester 1
      do_reset();
      set1(1'b1, 1'b0, '0, 32'h80, '0);
      for (int i = 0; i < 4; i++) begin
         set0(1'b1, i < 3, 4'hF, 32'h100 + 32'(4*i), 32'(i + 7));
         settle();
         chkb("t3_gnt0", 0, gnt0_v[0], 1'b1);
         chkb("t3_gnt1", 0, gnt1_v[0], 1'b0);
         if (i > 0) chkw("t3_owner", 0, DW'(owner_v[0]), 32'd1);
         clk();
      end
      set0(1'b0, 1'b0, '0, '0, '0);
      settle();
      chkb("t3_gnt1_5th", 0, gnt1_v[0], 1'b1);
      chkw("t3_owner_rel", 0, DW'(owner_v[0]), 32'd0);
      clk();
      set1(1'b0, 1'b0, '0, '0, '0);

      // requester 1 drops its lock request while requester 0 waits
      do_reset();
      set1(1'b1, 1'b1, '0, 32'h200, '0);
      settle();
      chkb("t4_gnt1", 0, gnt1_v[0], 1'b1);
      clk();
      set1(1'b0, 1'b0, '0, '0, '0);
      set0(1'b1, 1'b0, 4'hF, 32'h204, 32'h12345678);
      settle();
      chkw("t4_owner_lk", 0, DW'(owner_v[0]), 32'd2);
      chkb("t4_gnt0", 0, gnt0_v[0], 1'b1);
      clk();
      set0(1'b0, 1'b0, '0, '0, '0);
      settle();
      chkw("t4_owner_idle", 0, DW'(owner_v[0]), 32'd0);
      clk();

      // latency-3 read followed by a write
      do_reset();
      set1(1'b1, 1'b0, '0, 32'h20, '0);
      settle();
      chkb("t5_gnt1", 2, gnt1_v[2], 1'b1);
      clk();
      set1(1'b0, 1'b0, '0, '0, '0);
      set0(1'b1, 1'b0, 4'hF, 32'h24, 32'hCAFEF00D);
      for (int i = 1; i <= 4; i++) begin
         settle();
         chkb("t5_rv1", 2, rvalid1_v[2], i == 3);
         chkb("t5_rv0", 2, rvalid0_v[2], 1'b0);
         clk();
         if (i == 1) set0(1'b0, 1'b0, '0, '0, '0);
      end

      // reset with a read in flight
      do_reset();
      set0(1'b1, 1'b0, '0, 32'h30, '0);
      settle();
      chkb("t6_gnt0", 1, gnt0_v[1], 1'b1);
      clk();
      set0(1'b0, 1'b0, '0, '0, '0);
      reset = 1'b1;
      model_reset();
      settle();
      clk();
      reset = 1'b0;
      for (int i = 0; i < 4; i++) begin
         settle();
         chkb("t6_rv0", 1, rvalid0_v[1], 1'b0);
         chkb("t6_rv1", 1, rvalid1_v[1], 1'b0);
         clk();
      end
      set0(1'b1, 1'b0, '0, 32'h34, '0);
      set1(1'b1, 1'b0, '0, 32'h38, '0);
      settle();
      chkb("t6_tie_gnt0", 1, gnt0_v[1], 1'b1);
      chkb("t6_tie_gnt1", 1, gnt1_v[1], 1'b0);
      clk();

      // random traffic with occasional asynchronous reset
      rand0();
      rand1();
      for (int n = 0; n < 1500; n++) begin
         if (($urandom % 200) == 0) begin
            reset = 1'b1;
            model_reset();
            settle();
            clk();
            reset = 1'b0;
         end else begin
            settle();
            clk();
            if (win == 0 || !req0) rand0();
            if (win == 1 || !req1) rand1();
         end
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
